// File: rtl/i2c_master_param.sv
// i2c_master_param: single-master I2C engine moving one address byte plus
// DATA_BYTES payload bytes per transaction. Every bus phase is built from
// whole bit periods of 4*CLK_DIV clocks, so a single tick counter paces it all.
module i2c_master_param #(
    parameter int DATA_BYTES = 2,
    parameter int CLK_DIV    = 1
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    START_STB,
    input  logic                    RNW,
    input  logic [6:0]              I2C_ADDR,
    input  logic [8*DATA_BYTES-1:0] WR_DATA,
    input  logic                    SDA_IN,
    output logic                    SDA_OUT,
    output logic                    SDA_OE,
    output logic                    SCL,
    output logic [8*DATA_BYTES-1:0] RD_DATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    NACK_ERR
);

    localparam int PAY_W  = 8 * DATA_BYTES;
    localparam int TICK_W = $clog2(4 * CLK_DIV);
    localparam int BYTE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    // Positions inside one bit period.
    localparam logic [TICK_W-1:0] TICK_Q1   = TICK_W'(CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(2 * CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_Q3   = TICK_W'(3 * CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_SMP  = TICK_W'(3 * CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(4 * CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [TICK_W-1:0]   r_tick;
    logic [2:0]          r_bit_cnt;
    logic [BYTE_W-1:0]   r_byte_cnt;
    logic                r_rnw;
    logic [7:0]          r_addr_shift;
    logic [PAY_W-1:0]    r_tx_shift;
    logic [PAY_W-1:0]    r_rx_shift;
    logic [PAY_W-1:0]    r_rd_data;
    logic                r_sda_smp;
    logic                r_nack_err;
    logic                r_done;

    logic                w_bit_end;
    logic                w_sample;
    logic                w_last_bit;
    logic                w_last_byte;
    logic                w_scl_bit;
    logic                w_scl;
    logic                w_sda_oe;
    logic                w_sda_out;

    assign w_bit_end   = (r_tick == TICK_LAST);
    assign w_sample    = (r_tick == TICK_SMP);
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_scl_bit   = (r_tick >= TICK_HALF);

    // State register; reset wins over everything, including a pending strobe.
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register sees pre-edge values of the others, independent of order.
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and bus drive values for the current phase.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_scl        = 1'b1;
        w_sda_oe     = 1'b0;
        w_sda_out    = 1'b1;
        case (r_state)
            IDLE: begin
                if (START_STB) w_next_state = START;
            end
            START: begin
                w_sda_oe  = 1'b1;
                w_sda_out = (r_tick < TICK_HALF);
                if (w_bit_end) w_next_state = ADDR;
            end
            ADDR: begin
                w_scl     = w_scl_bit;
                w_sda_oe  = 1'b1;
                w_sda_out = r_addr_shift[7];
                if (w_bit_end && w_last_bit) w_next_state = ACK_A;
            end
            ACK_A: begin
                w_scl = w_scl_bit;
                if (w_bit_end) w_next_state = r_sda_smp ? STOP : DATA;
            end
            DATA: begin
                w_scl     = w_scl_bit;
                w_sda_oe  = !r_rnw;
                w_sda_out = r_rnw ? 1'b1 : r_tx_shift[PAY_W-1];
                if (w_bit_end && w_last_bit) w_next_state = ACK_D;
            end
            ACK_D: begin
                // On reads the master answers: ACK for more, NACK on the last byte.
                w_scl     = w_scl_bit;
                w_sda_oe  = r_rnw;
                w_sda_out = r_rnw ? w_last_byte : 1'b1;
                if (w_bit_end) begin
                    if ((!r_rnw && r_sda_smp) || w_last_byte) w_next_state = STOP;
                    else                                      w_next_state = DATA;
                end
            end
            STOP: begin
                w_scl     = (r_tick >= TICK_Q1);
                w_sda_oe  = 1'b1;
                w_sda_out = (r_tick >= TICK_Q3);
                if (w_bit_end) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Tick, bit and byte counters; all parked at zero while idle.
    always_ff @(posedge clk) begin
        if (RESET || r_state == IDLE) begin
            r_tick     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
            // The 3-bit counter rolls 7 -> 0 exactly as each byte finishes.
            if (w_bit_end && (r_state == ADDR || r_state == DATA)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_bit_end && r_state == ACK_D && !w_last_byte) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    // Request capture, shift registers, SDA sampling and status flags.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_rnw        <= 1'b0;
            r_addr_shift <= '0;
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_rd_data    <= '0;
            r_sda_smp    <= 1'b1;
            r_nack_err   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == STOP) && w_bit_end;
            if (w_sample) r_sda_smp <= SDA_IN;
            case (r_state)
                IDLE: begin
                    if (START_STB) begin
                        r_rnw        <= RNW;
                        r_addr_shift <= {I2C_ADDR, RNW};
                        r_tx_shift   <= WR_DATA;
                        r_nack_err   <= 1'b0;
                    end
                end
                ADDR: begin
                    if (w_bit_end) r_addr_shift <= {r_addr_shift[6:0], 1'b0};
                end
                ACK_A: begin
                    if (w_bit_end && r_sda_smp) r_nack_err <= 1'b1;
                end
                DATA: begin
                    if (w_bit_end && !r_rnw) r_tx_shift <= {r_tx_shift[PAY_W-2:0], 1'b0};
                    if (w_sample && r_rnw)   r_rx_shift <= {r_rx_shift[PAY_W-2:0], SDA_IN};
                end
                ACK_D: begin
                    if (w_bit_end && !r_rnw && r_sda_smp) r_nack_err <= 1'b1;
                end
                STOP: begin
                    // Only a read that got past its address publishes new data.
                    if (w_bit_end && r_rnw && !r_nack_err) r_rd_data <= r_rx_shift;
                end
                default: begin
                end
            endcase
        end
    end

    assign SCL      = w_scl;
    assign SDA_OE   = w_sda_oe;
    assign SDA_OUT  = w_sda_out;
    assign BUSY     = (r_state != IDLE);
    assign DONE     = r_done;
    assign NACK_ERR = r_nack_err;
    assign RD_DATA  = r_rd_data;

endmodule

// File: tb/tb_i2c_master_param.sv
// Bench for i2c_master_param: a slot-level bus model (bit slots of 4*CLK_DIV
// clocks) predicts SCL/SDA per clock, acts as the slave and tracks RD_DATA.
module tb_i2c_master_param;

    localparam int DB    = 2;
    localparam int CD    = 1;
    localparam int BP    = 4 * CD;
    localparam int PAY_W = 8 * DB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (DATA_BYTES=2, CLK_DIV=1).
    logic             RESET, START_STB, RNW, SDA_IN;
    logic [6:0]       I2C_ADDR;
    logic [PAY_W-1:0] WR_DATA, RD_DATA;
    logic             SDA_OUT, SDA_OE, SCL, BUSY, DONE, NACK_ERR;

    i2c_master_param #(.DATA_BYTES(DB), .CLK_DIV(CD)) dut (
        .clk(clk), .RESET(RESET), .START_STB(START_STB), .RNW(RNW),
        .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA), .SDA_IN(SDA_IN),
        .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE), .SCL(SCL), .RD_DATA(RD_DATA),
        .BUSY(BUSY), .DONE(DONE), .NACK_ERR(NACK_ERR)
    );

    // Second instance (DATA_BYTES=1, CLK_DIV=3).
    logic       p_reset, p_start, p_rnw, p_sda_in;
    logic [6:0] p_addr;
    logic [7:0] p_wr_data, p_rd_data;
    logic       p_sda_out, p_sda_oe, p_scl, p_busy, p_done, p_nack;

    i2c_master_param #(.DATA_BYTES(1), .CLK_DIV(3)) dut_p (
        .clk(clk), .RESET(p_reset), .START_STB(p_start), .RNW(p_rnw),
        .I2C_ADDR(p_addr), .WR_DATA(p_wr_data), .SDA_IN(p_sda_in),
        .SDA_OUT(p_sda_out), .SDA_OE(p_sda_oe), .SCL(p_scl), .RD_DATA(p_rd_data),
        .BUSY(p_busy), .DONE(p_done), .NACK_ERR(p_nack)
    );

    typedef struct {
        logic             rnw;
        logic [6:0]       addr;
        logic [PAY_W-1:0] wdata;
        logic             addr_nack;   // slave NACKs the address
        int               nack_byte;   // write byte the slave NACKs, -1 = none
        logic [PAY_W-1:0] slave_rd;    // bytes the slave returns on a read
        logic             busy_poke;   // fire a stray START_STB mid-transfer
        int               exp_lat;
        logic             exp_nack;
        logic [PAY_W-1:0] exp_rd;
    } txn_vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Number of bit slots: START, 8 address, ACK, 9 per byte sent, STOP.
    function automatic int nslots_of(input txn_vec_t v);
        if (v.addr_nack) return 11;
        if (!v.rnw && v.nack_byte >= 0) return 11 + 9 * (v.nack_byte + 1);
        return 11 + 9 * DB;
    endfunction

    // Expected {SCL, SDA_OE, SDA_OE & SDA_OUT} at clock c after the first START clock.
    function automatic logic [2:0] bus_expect(input int c, input txn_vec_t v, input int nslots);
        int slot, t, s, k, b;
        logic [7:0] ab, byte_k;
        logic scl, oe, out;
        slot = c / BP;
        t    = c % BP;
        ab   = {v.addr, v.rnw};
        scl = 1'b1; oe = 1'b0; out = 1'b0;
        if (slot == 0) begin
            oe = 1'b1; out = (t < 2 * CD);
        end else if (slot == nslots - 1) begin
            oe = 1'b1; scl = (t >= CD); out = (t >= 3 * CD);
        end else begin
            s = slot - 1;
            scl = (t >= 2 * CD);
            if (s < 8) begin
                oe = 1'b1; out = ab[7 - s];
            end else if (s > 8) begin
                k = (s - 9) / 9;
                b = (s - 9) % 9;
                byte_k = v.wdata[8 * (DB - 1 - k) +: 8];
                if (b < 8) begin
                    oe = !v.rnw; out = v.rnw ? 1'b0 : byte_k[7 - b];
                end else begin
                    oe = v.rnw; out = (k == DB - 1);
                end
            end
        end
        return {scl, oe, oe & out};
    endfunction

    // Slave drive on SDA_IN for clock c.
    function automatic logic slave_sda(input int c, input txn_vec_t v);
        int s, k, b;
        s = c / BP - 1;
        if (s == 8) return v.addr_nack;
        if (s > 8) begin
            k = (s - 9) / 9;
            b = (s - 9) % 9;
            if (k < DB) begin
                if (b < 8 && v.rnw)   return v.slave_rd[8 * (DB - 1 - k) + 7 - b];
                if (b == 8 && !v.rnw) return (k == v.nack_byte);
            end
        end
        return 1'b1;
    endfunction

    task automatic run_txn(input int idx, input txn_vec_t v);
        int nslots, done_at;
        logic [4:0] got, exp;
        logic [2:0] bx;
        nslots  = nslots_of(v);
        done_at = -1;
        @(posedge clk); #1;
        START_STB = 1'b1; RNW = v.rnw; I2C_ADDR = v.addr; WR_DATA = v.wdata;
        @(posedge clk); #1;
        START_STB = 1'b0;
        for (int c = 0; c <= v.exp_lat + 1; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            SDA_IN = slave_sda(c, v);
            if (v.busy_poke && c == 10) begin
                START_STB = 1'b1; RNW = ~v.rnw; I2C_ADDR = ~v.addr; WR_DATA = ~v.wdata;
            end else begin
                START_STB = 1'b0;
            end
            if (c == 0) check($sformatf("v%0d nack_cleared", idx), NACK_ERR, 1'b0);
            if (DONE && done_at < 0) done_at = c;
            if (c < v.exp_lat) begin
                bx  = bus_expect(c, v, nslots);
                exp = {bx, 1'b1, 1'b0};
            end else if (c == v.exp_lat) begin
                exp = 5'b10001;
            end else begin
                exp = 5'b10000;
            end
            got = {SCL, SDA_OE, SDA_OE & SDA_OUT, BUSY, DONE};
            check($sformatf("v%0d bus{scl,oe,out,busy,done} c=%0d", idx, c), got, exp);
        end
        check($sformatf("v%0d done_latency", idx), 64'(done_at), 64'(v.exp_lat));
        check($sformatf("v%0d nack_err", idx), NACK_ERR, v.exp_nack);
        check($sformatf("v%0d rd_data", idx), RD_DATA, v.exp_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        txn_vec_t vecs[8];
        txn_vec_t rv;
        logic [PAY_W-1:0] model_rd;
        int done_at, bad_scl, bad_oe, slot, t;
        logic seen_done;
        logic [15:0] stream;

        RESET = 1'b1; START_STB = 1'b0; RNW = 1'b0; I2C_ADDR = '0; WR_DATA = '0; SDA_IN = 1'b1;
        p_reset = 1'b1; p_start = 1'b0; p_rnw = 1'b0; p_addr = '0; p_wr_data = '0; p_sda_in = 1'b1;

        // Directed table: {rnw, addr, wdata, addr_nack, nack_byte, slave_rd, poke, lat, nack, rd}.
        vecs[0] = '{rnw:1'b0, addr:7'h02, wdata:16'h00FF, addr_nack:1'b0, nack_byte:-1, slave_rd:16'h0000, busy_poke:1'b0, exp_lat:116, exp_nack:1'b0, exp_rd:16'h0000};
        vecs[1] = '{rnw:1'b0, addr:7'h02, wdata:16'h00FF, addr_nack:1'b1, nack_byte:-1, slave_rd:16'h0000, busy_poke:1'b0, exp_lat:44,  exp_nack:1'b1, exp_rd:16'h0000};
        vecs[2] = '{rnw:1'b1, addr:7'h11, wdata:16'h0000, addr_nack:1'b0, nack_byte:-1, slave_rd:16'hA53C, busy_poke:1'b0, exp_lat:116, exp_nack:1'b0, exp_rd:16'hA53C};
        vecs[3] = '{rnw:1'b0, addr:7'h7F, wdata:16'h1234, addr_nack:1'b0, nack_byte:0,  slave_rd:16'h0000, busy_poke:1'b0, exp_lat:80,  exp_nack:1'b1, exp_rd:16'hA53C};
        vecs[4] = '{rnw:1'b1, addr:7'h2A, wdata:16'h0000, addr_nack:1'b1, nack_byte:-1, slave_rd:16'hFFFF, busy_poke:1'b0, exp_lat:44,  exp_nack:1'b1, exp_rd:16'hA53C};
        vecs[5] = '{rnw:1'b0, addr:7'h40, wdata:16'hBEEF, addr_nack:1'b0, nack_byte:1,  slave_rd:16'h0000, busy_poke:1'b1, exp_lat:116, exp_nack:1'b1, exp_rd:16'hA53C};
        vecs[6] = '{rnw:1'b1, addr:7'h33, wdata:16'h0000, addr_nack:1'b0, nack_byte:-1, slave_rd:16'hFF00, busy_poke:1'b1, exp_lat:116, exp_nack:1'b0, exp_rd:16'hFF00};
        vecs[7] = '{rnw:1'b0, addr:7'h02, wdata:16'h00FF, addr_nack:1'b0, nack_byte:-1, slave_rd:16'h0000, busy_poke:1'b1, exp_lat:116, exp_nack:1'b0, exp_rd:16'hFF00};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {SCL, SDA_OE, SDA_OUT, BUSY, DONE, NACK_ERR}, 6'b101000);
        RESET = 1'b0; p_reset = 1'b0;
        @(posedge clk); #1;
        check("idle outputs", {SCL, SDA_OE, SDA_OUT, BUSY, DONE, NACK_ERR}, 6'b101000);
        check("idle rd_data", RD_DATA, 16'h0000);

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Randomized transactions against the slot model.
        model_rd = 16'hFF00;
        for (int i = 0; i < 10; i++) begin
            rv.rnw       = 1'($urandom_range(0, 1));
            rv.addr      = 7'($urandom);
            rv.wdata     = PAY_W'($urandom);
            rv.addr_nack = ($urandom_range(0, 4) == 0);
            rv.nack_byte = (!rv.rnw && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
            rv.slave_rd  = PAY_W'($urandom);
            rv.busy_poke = 1'($urandom_range(0, 1));
            rv.exp_lat   = nslots_of(rv) * BP;
            rv.exp_nack  = rv.addr_nack || (!rv.rnw && rv.nack_byte >= 0);
            if (rv.rnw && !rv.addr_nack) model_rd = rv.slave_rd;
            rv.exp_rd    = model_rd;
            run_txn(100 + i, rv);
        end

        // Abort: reset during the second data byte of a write.
        @(posedge clk); #1;
        START_STB = 1'b1; RNW = 1'b0; I2C_ADDR = 7'h5A; WR_DATA = 16'hC3A5; SDA_IN = 1'b0;
        @(posedge clk); #1;
        START_STB = 1'b0;
        repeat (22 * BP + 2) @(posedge clk);
        #1;
        check("abort in busy", BUSY, 1'b1);
        RESET = 1'b1;
        @(posedge clk); #1;
        RESET = 1'b0;
        check("abort outputs", {SCL, SDA_OE, BUSY, DONE, NACK_ERR}, 5'b10000);
        check("abort rd_data", RD_DATA, 16'h0000);
        seen_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (DONE || BUSY) seen_done = 1'b1;
        end
        check("abort no done/busy", seen_done, 1'b0);

        // Reset beats a simultaneous strobe.
        @(posedge clk); #1;
        RESET = 1'b1; START_STB = 1'b1; RNW = 1'b0; I2C_ADDR = 7'h01;
        @(posedge clk); #1;
        RESET = 1'b0; START_STB = 1'b0;
        check("reset priority busy", BUSY, 1'b0);
        @(posedge clk); #1;
        check("reset priority stays idle", {SCL, SDA_OE, BUSY}, 3'b100);

        // Parameter variant: 1 byte, CLK_DIV=3 (12-clock bit, 20 slots).
        @(posedge clk); #1;
        p_start = 1'b1; p_rnw = 1'b0; p_addr = 7'h02; p_wr_data = 8'h5A; p_sda_in = 1'b0;
        @(posedge clk); #1;
        p_start = 1'b0;
        done_at = -1; bad_scl = 0; bad_oe = 0; stream = '0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (p_done && done_at < 0) done_at = c;
            slot = c / 12;
            t    = c % 12;
            if (slot >= 1 && slot <= 18 && p_scl !== (t >= 6)) bad_scl++;
            if (t == 6 && ((slot >= 1 && slot <= 8) || (slot >= 10 && slot <= 17))) begin
                stream = {stream[14:0], p_sda_out};
                if (p_sda_oe !== 1'b1) bad_oe++;
            end
        end
        check("p done_latency", 64'(done_at), 64'(240));
        check("p scl 6/6 shape bad clocks", 64'(bad_scl), 64'(0));
        check("p stream oe bad bits", 64'(bad_oe), 64'(0));
        check("p serial stream", stream, 16'h045A);
        check("p nack_err", p_nack, 1'b0);
        check("p rd_data untouched", p_rd_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master_param.md
I2C_MASTER_PARAM -- requirements
Module: i2c_master_param

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2, meaning data bytes per transaction (legal 1..4).
REQ-002 SHALL have parameter CLK_DIV, default 1, meaning clk cycles per SCL quarter-period (legal >=1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port START_STB, input, 1 bit: one-cycle transaction request.
REQ-006 SHALL have port RNW, input, 1 bit: 1 = read, 0 = write.
REQ-007 SHALL have port I2C_ADDR, input, 7 bits: target address.
REQ-008 SHALL have port WR_DATA, input, 8*DATA_BYTES bits: write payload, MSB byte sent first.
REQ-009 SHALL have port SDA_IN, input, 1 bit: sampled bus SDA.
REQ-010 SHALL have port SDA_OUT, output, 1 bit: SDA drive value.
REQ-011 SHALL have port SDA_OE, output, 1 bit: SDA drive enable; 0 releases the bus.
REQ-012 SHALL have port SCL, output, 1 bit: generated serial clock.
REQ-013 SHALL have port RD_DATA, output, 8*DATA_BYTES bits: read payload, first byte received in MSB.
REQ-014 SHALL have ports BUSY, DONE and NACK_ERR, all outputs, 1 bit each: transaction active, one-cycle completion pulse, sticky NACK flag.

Function
REQ-015 SHALL implement states IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP.
REQ-016 Bit period (BP) SHALL be 4*CLK_DIV clocks; in ADDR/ACK/DATA, SCL is 0 for the first 2*CLK_DIV clocks and 1 for the last 2*CLK_DIV.
REQ-017 SDA_OUT/SDA_OE SHALL change only on the first clock of a bit; SDA_IN SHALL be sampled on clock 3*CLK_DIV-1 of the bit.
REQ-018 IDLE outputs: SCL=1, SDA_OE=0, SDA_OUT=1, BUSY=0.
REQ-019 START_STB in IDLE SHALL latch RNW, I2C_ADDR and WR_DATA, set BUSY=1, clear NACK_ERR and enter START on the next cycle.
REQ-020 START_STB while BUSY=1 SHALL be ignored, with no effect on the latched inputs.
REQ-021 START (1 BP): SCL=1, SDA_OE=1, SDA_OUT=1 for the first half and 0 for the second half.
REQ-022 ADDR (8 bits): SHALL send {I2C_ADDR, RNW} MSB-first, SDA_OE=1.
REQ-023 ACK_A: SDA_OE=0; sampled 0 -> DATA; sampled 1 -> NACK_ERR=1 and go to STOP.
REQ-024 Write DATA: SHALL send latched byte k (k=0 is the MSB byte) MSB-first; ACK_D releases SDA; NACK -> NACK_ERR=1 and STOP; ACK -> next byte, or STOP after the last byte.
REQ-025 Read DATA: SDA_OE=0, shifting in 8 bits; in ACK_D, SDA_OE=1, SDA_OUT=0 (ACK) for bytes other than the last and SDA_OUT=1 (NACK) for the last; NACK_ERR is never set on reads.
REQ-026 STOP (1 BP): SDA_OE=1, SDA_OUT=0; SCL=0 for the first quarter and 1 for the rest; SDA_OUT=1 for the last quarter.
REQ-027 On the clock after STOP ends: state IDLE, BUSY=0, DONE=1 for exactly one cycle; for reads, RD_DATA updates on this same cycle.
REQ-028 Full-transaction latency SHALL be (11+9*DATA_BYTES)*BP clocks from the first START clock to DONE.
REQ-029 Address-NACK latency SHALL be 11*BP clocks.
REQ-030 A data NACK on byte k SHALL skip the remaining bytes.
REQ-031 NACK_ERR SHALL hold until the next accepted START_STB or RESET.
REQ-032 RD_DATA SHALL hold its value between transactions and SHALL be unchanged by write or NACKed transactions.
REQ-033 Bit and byte counters SHALL cover exactly 8 bits and DATA_BYTES bytes, with no wrap beyond them.

Reset
REQ-034 RESET=1 at any clock SHALL force the next state to IDLE with SCL=1, SDA_OE=0, SDA_OUT=1, BUSY=0, DONE=0, NACK_ERR=0 and RD_DATA=0.
REQ-035 RESET mid-transaction SHALL abort without a STOP condition and without a DONE pulse.
REQ-036 RESET SHALL take priority over a simultaneous START_STB, which is dropped.

Verification (DATA_BYTES=2, CLK_DIV=1, BP=4 unless noted)
REQ-037 Write test: addr 7'h02, RNW=0, WR_DATA 16'h00FF, SDA_IN=0 in ACK slots -> serial stream 0000010_0, 00000000, 11111111; DONE 116 clocks after START; NACK_ERR=0.
REQ-038 Address NACK test: SDA_IN=1 in ACK_A -> STOP follows immediately; DONE at 44 clocks; NACK_ERR=1; no data bits sent.
REQ-039 Read test: RNW=1, slave returns 8'hA5 then 8'h3C -> RD_DATA=16'hA53C at DONE; master drives ACK (OE=1, OUT=0) after byte 0 and NACK (OUT=1) after byte 1.
REQ-040 Abort test: RESET pulse during the second DATA byte -> next cycle SCL=1, SDA_OE=0, BUSY=0; no DONE pulse.
REQ-041 Busy test: START_STB asserted mid-transfer with a new address -> ignored; the stream still carries the original address.
REQ-042 Parameter test: DATA_BYTES=1, CLK_DIV=3 write -> DONE at 20*12=240 clocks; SCL high/low intervals of 6 clocks each.
